// File: rtl/parking_timer.sv
// parking_timer: per-slot occupancy timers driven by a 1 Hz tick, plus a
// display controller that shows an exiting car's parked duration for a
// fixed hold time before returning the display to capacity mode.
module parking_timer #(
  parameter int TICK_DIV = 40_000_000,
  parameter int HOLD_SEC = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       entry_signal,
  input  logic [1:0] entry_slot,
  input  logic       exit_signal,
  input  logic [1:0] exit_slot,
  output logic       mode,
  output logic [5:0] minutes,
  output logic [5:0] seconds,
  output logic [3:0] occupied,
  output logic       exit_valid
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  typedef enum logic {SHOW_CAP, SHOW_TIME} state_t;

  logic [PW-1:0]      pre_cnt;
  logic               tick;
  logic [3:0]         occ;
  logic [3:0][5:0]    slot_min;
  logic [3:0][5:0]    slot_sec;
  logic               entry_ok;
  logic               exit_ok;
  state_t             state, state_n;
  logic [5:0]         hold, hold_n;
  logic [5:0]         min_n, sec_n;
  logic               mode_n, ev_n;

  // One-second advance of a mm:ss count, pinned at 59:59 instead of wrapping.
  function automatic logic [11:0] advance_sat(input logic [5:0] m, input logic [5:0] s);
    if (m == 6'd59 && s == 6'd59) return {m, s};
    else if (s == 6'd59)          return {m + 6'd1, 6'd0};
    else                          return {m, s + 6'd1};
  endfunction

  assign tick     = (pre_cnt == PW'(TICK_DIV - 1));
  // An exit on a free slot and an entry on an occupied slot are both
  // meaningless, so they are filtered here; this also resolves same-slot
  // entry+exit collisions in favour of whichever one is legal.
  assign exit_ok  = exit_signal  &  occ[exit_slot];
  assign entry_ok = entry_signal & ~occ[entry_slot];
  assign occupied = occ;

  // Prescaler: wraps every TICK_DIV cycles, tick on the last count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pre_cnt <= '0;
    else        pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
  end

  // Slot counters: exit clears, entry starts at 0:00, tick advances occupied slots.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occ      <= '0;
      slot_min <= '0;
      slot_sec <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (exit_ok && exit_slot == 2'(i)) begin
          occ[i]      <= 1'b0;
          slot_min[i] <= 6'd0;
          slot_sec[i] <= 6'd0;
        end else if (entry_ok && entry_slot == 2'(i)) begin
          occ[i]      <= 1'b1;
          slot_min[i] <= 6'd0;
          slot_sec[i] <= 6'd0;
        end else if (tick && occ[i]) begin
          {slot_min[i], slot_sec[i]} <= advance_sat(slot_min[i], slot_sec[i]);
        end
      end
    end
  end

  // Display FSM register together with its registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= SHOW_CAP;
      hold       <= 6'd0;
      minutes    <= 6'd0;
      seconds    <= 6'd0;
      mode       <= 1'b0;
      exit_valid <= 1'b0;
    end else begin
      state      <= state_n;
      hold       <= hold_n;
      minutes    <= min_n;
      seconds    <= sec_n;
      mode       <= mode_n;
      exit_valid <= ev_n;
    end
  end

  // Next-state: a valid exit always wins over the hold countdown.
  always_comb begin
    state_n = state;
    hold_n  = hold;
    min_n   = minutes;
    sec_n   = seconds;
    ev_n    = 1'b0;
    if (exit_ok) begin
      state_n = SHOW_TIME;
      hold_n  = 6'(HOLD_SEC);
      min_n   = slot_min[exit_slot];
      sec_n   = slot_sec[exit_slot];
      ev_n    = 1'b1;
    end else if (state == SHOW_TIME && tick) begin
      if (hold == 6'd1) begin
        state_n = SHOW_CAP;
        hold_n  = 6'd0;
        min_n   = 6'd0;
        sec_n   = 6'd0;
      end else begin
        hold_n  = hold - 6'd1;
      end
    end
    mode_n = (state_n == SHOW_TIME);
  end

endmodule

// File: tb/tb_parking_timer.sv
// Directed bench for parking_timer with TICK_DIV=4, HOLD_SEC=5.
// Inputs change on the falling edge; "cyc" is the index of the next rising
// edge counted from reset release, so ticks land on cycles with cyc%4==3.
module tb_parking_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       entry_signal, exit_signal;
  logic [1:0] entry_slot, exit_slot;
  logic       mode, exit_valid;
  logic [5:0] minutes, seconds;
  logic [3:0] occupied;

  int cyc;
  int checks = 0;
  int errors = 0;

  parking_timer #(.TICK_DIV(4), .HOLD_SEC(5)) dut (
    .clk(clk), .reset(reset),
    .entry_signal(entry_signal), .entry_slot(entry_slot),
    .exit_signal(exit_signal), .exit_slot(exit_slot),
    .mode(mode), .minutes(minutes), .seconds(seconds),
    .occupied(occupied), .exit_valid(exit_valid)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    reset = 1'b0;
    entry_signal = 1'b0; exit_signal = 1'b0;
    entry_slot = 2'd0;   exit_slot = 2'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cyc = 0;
  endtask

  task automatic goto_cyc(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Present one cycle of entry/exit pulses at the current cycle.
  task automatic ev(input logic e, input logic [1:0] es, input logic x, input logic [1:0] xs);
    entry_signal = e; entry_slot = es;
    exit_signal  = x; exit_slot  = xs;
    @(negedge clk);
    cyc++;
    entry_signal = 1'b0; exit_signal = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL reset_mode: got %b want 0", mode); end
    checks++; if (minutes !== 6'd0) begin errors++; $display("FAIL reset_min: got %0d want 0", minutes); end
    checks++; if (seconds !== 6'd0) begin errors++; $display("FAIL reset_sec: got %0d want 0", seconds); end
    checks++; if (occupied !== 4'b0000) begin errors++; $display("FAIL reset_occ: got %b want 0000", occupied); end
    checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL reset_ev: got %b want 0", exit_valid); end
    ev(1'b1, 2'd0, 1'b0, 2'd0);
    ev(1'b1, 2'd1, 1'b0, 2'd0);
    goto_cyc(8);
    ev(1'b0, 2'd0, 1'b1, 2'd0);
    checks++; if (mode !== 1'b1 || seconds !== 6'd2) begin errors++; $display("FAIL pre_areset: got mode=%b sec=%0d want mode=1 sec=2", mode, seconds); end
    #2 reset = 1'b0;
    #1;
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL areset_mode: got %b want 0", mode); end
    checks++; if (minutes !== 6'd0 || seconds !== 6'd0) begin errors++; $display("FAIL areset_time: got %0d:%0d want 0:0", minutes, seconds); end
    checks++; if (occupied !== 4'b0000) begin errors++; $display("FAIL areset_occ: got %b want 0000", occupied); end
    checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL areset_ev: got %b want 0", exit_valid); end
  endtask

  task automatic test_basic();
    do_reset();
    ev(1'b1, 2'd2, 1'b0, 2'd0);
    goto_cyc(300);
    checks++; if (occupied !== 4'b0100) begin errors++; $display("FAIL basic_occ_before: got %b want 0100", occupied); end
    ev(1'b0, 2'd0, 1'b1, 2'd2);
    checks++; if (exit_valid !== 1'b1) begin errors++; $display("FAIL basic_ev: got %b want 1", exit_valid); end
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL basic_mode: got %b want 1", mode); end
    checks++; if (minutes !== 6'd1 || seconds !== 6'd15) begin errors++; $display("FAIL basic_time: got %0d:%0d want 1:15", minutes, seconds); end
    checks++; if (occupied !== 4'b0000) begin errors++; $display("FAIL basic_occ_after: got %b want 0000", occupied); end
    goto_cyc(302);
    checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL basic_ev_pulse: got %b want 0", exit_valid); end
    goto_cyc(319);
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL basic_hold_end: got %b want 1", mode); end
    goto_cyc(320);
    checks++; if (mode !== 1'b0) begin errors++; $display("FAIL basic_back_cap: got %b want 0", mode); end
    checks++; if (minutes !== 6'd0 || seconds !== 6'd0) begin errors++; $display("FAIL basic_clear: got %0d:%0d want 0:0", minutes, seconds); end
  endtask

  task automatic test_saturation();
    do_reset();
    ev(1'b1, 2'd0, 1'b0, 2'd0);
    goto_cyc(14800);
    ev(1'b0, 2'd0, 1'b1, 2'd0);
    checks++; if (minutes !== 6'd59 || seconds !== 6'd59) begin errors++; $display("FAIL sat_time: got %0d:%0d want 59:59", minutes, seconds); end
    checks++; if (exit_valid !== 1'b1) begin errors++; $display("FAIL sat_ev: got %b want 1", exit_valid); end
    ev(1'b0, 2'd0, 1'b1, 2'd3);
    checks++; if (exit_valid !== 1'b0) begin errors++; $display("FAIL free_exit_ev: got %b want 0", exit_valid); end
    checks++; if (mode !== 1'b1 || minutes !== 6'd59) begin errors++; $display("FAIL free_exit_disp: got mode=%b min=%0d want mode=1 min=59", mode, minutes); end
  endtask

  task automatic test_illegal_entry();
    do_reset();
    ev(1'b1, 2'd1, 1'b0, 2'd0);
    ev(1'b0, 2'd0, 1'b1, 2'd3);
    checks++; if (exit_valid !== 1'b0 || mode !== 1'b0) begin errors++; $display("FAIL free_exit_cap: got ev=%b mode=%b want 0 0", exit_valid, mode); end
    checks++; if (occupied !== 4'b0010) begin errors++; $display("FAIL free_exit_occ: got %b want 0010", occupied); end
    goto_cyc(40);
    ev(1'b1, 2'd1, 1'b0, 2'd0);
    checks++; if (occupied !== 4'b0010) begin errors++; $display("FAIL dup_entry_occ: got %b want 0010", occupied); end
    goto_cyc(80);
    ev(1'b0, 2'd0, 1'b1, 2'd1);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd20) begin errors++; $display("FAIL dup_entry_time: got %0d:%0d want 0:20", minutes, seconds); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    ev(1'b1, 2'd0, 1'b0, 2'd0);
    goto_cyc(40);
    ev(1'b1, 2'd1, 1'b1, 2'd0);
    checks++; if (occupied !== 4'b0010) begin errors++; $display("FAIL simul_occ: got %b want 0010", occupied); end
    checks++; if (minutes !== 6'd0 || seconds !== 6'd10) begin errors++; $display("FAIL simul_time: got %0d:%0d want 0:10", minutes, seconds); end
    checks++; if (exit_valid !== 1'b1 || mode !== 1'b1) begin errors++; $display("FAIL simul_ev: got ev=%b mode=%b want 1 1", exit_valid, mode); end
    goto_cyc(44);
    ev(1'b1, 2'd3, 1'b0, 2'd0);
    goto_cyc(60);
    ev(1'b1, 2'd3, 1'b1, 2'd3);
    checks++; if (occupied !== 4'b0010) begin errors++; $display("FAIL same_occ_slot: got %b want 0010", occupied); end
    checks++; if (exit_valid !== 1'b1 || seconds !== 6'd4) begin errors++; $display("FAIL same_occ_capture: got ev=%b sec=%0d want 1 4", exit_valid, seconds); end
    goto_cyc(62);
    ev(1'b1, 2'd3, 1'b1, 2'd3);
    checks++; if (occupied !== 4'b1010) begin errors++; $display("FAIL same_free_slot: got %b want 1010", occupied); end
    checks++; if (exit_valid !== 1'b0 || seconds !== 6'd4) begin errors++; $display("FAIL same_free_ev: got ev=%b sec=%0d want 0 4", exit_valid, seconds); end
  endtask

  task automatic test_retrigger();
    do_reset();
    goto_cyc(8);
    ev(1'b1, 2'd1, 1'b0, 2'd0);
    goto_cyc(100);
    ev(1'b1, 2'd0, 1'b0, 2'd0);
    goto_cyc(180);
    ev(1'b0, 2'd0, 1'b1, 2'd0);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd20) begin errors++; $display("FAIL retrig_first: got %0d:%0d want 0:20", minutes, seconds); end
    goto_cyc(188);
    ev(1'b0, 2'd0, 1'b1, 2'd1);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd45) begin errors++; $display("FAIL retrig_second: got %0d:%0d want 0:45", minutes, seconds); end
    checks++; if (exit_valid !== 1'b1) begin errors++; $display("FAIL retrig_ev: got %b want 1", exit_valid); end
    goto_cyc(201);
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL retrig_reload: got %b want 1", mode); end
    goto_cyc(207);
    checks++; if (mode !== 1'b1) begin errors++; $display("FAIL retrig_last: got %b want 1", mode); end
    goto_cyc(208);
    checks++; if (mode !== 1'b0 || seconds !== 6'd0) begin errors++; $display("FAIL retrig_done: got mode=%b sec=%0d want 0 0", mode, seconds); end
  endtask

  task automatic test_tick_coincidence();
    do_reset();
    ev(1'b1, 2'd2, 1'b0, 2'd0);
    goto_cyc(39);
    ev(1'b0, 2'd0, 1'b1, 2'd2);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd9) begin errors++; $display("FAIL tick_exit: got %0d:%0d want 0:9", minutes, seconds); end
    goto_cyc(43);
    ev(1'b1, 2'd0, 1'b0, 2'd0);
    ev(1'b0, 2'd0, 1'b1, 2'd0);
    checks++; if (exit_valid !== 1'b1 || seconds !== 6'd0) begin errors++; $display("FAIL tick_entry_zero: got ev=%b sec=%0d want 1 0", exit_valid, seconds); end
    goto_cyc(51);
    ev(1'b1, 2'd1, 1'b0, 2'd0);
    goto_cyc(56);
    ev(1'b0, 2'd0, 1'b1, 2'd1);
    checks++; if (minutes !== 6'd0 || seconds !== 6'd1) begin errors++; $display("FAIL tick_entry_one: got %0d:%0d want 0:1", minutes, seconds); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_illegal_entry();
    test_simultaneous();
    test_retrigger();
    test_tick_coincidence();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/parking_timer.md
Name: parking_timer

Overview:
- Time-keeping producer for the parking design.
- Tracks how long each of the 4 slots has been occupied, using an internal 1 Hz tick derived from the system clock.
- When a car exits, it captures that slot's duration and drives mode/minutes/seconds into the multiplexed display for a fixed hold time, then returns the display to capacity mode.
- Sits between the parking FSM outputs (entry/exit pulses, slot indices) and the display's time inputs.

Parameters:
- TICK_DIV, 40_000_000: clk cycles per 1 s tick. Benches use 4.
- HOLD_SEC, 5: ticks that the time display is held after an exit (1..63).

Ports:
- clk  input  1  system clock (40 MHz).
- reset  input  1  asynchronous, active-low reset.
- entry_signal  input  1  one-cycle pulse: a car parks in entry_slot.
- entry_slot  input  2  slot being filled (FSM location).
- exit_signal  input  1  one-cycle pulse: a car leaves exit_slot.
- exit_slot  input  2  slot being freed.
- mode  output  1  0 = capacity display, 1 = time display.
- minutes  output  6  captured duration minutes, 0..59.
- seconds  output  6  captured duration seconds, 0..59.
- occupied  output  4  per-slot occupied flags as tracked by this block.
- exit_valid  output  1  one-cycle pulse when a duration is captured.

Behaviour:
- **Clock and reset**
  - One clock domain.
  - reset low asynchronously clears everything: mode=0, minutes=0, seconds=0, occupied=0, exit_valid=0, all slot counters 0:00, prescaler 0, hold counter 0, FSM to SHOW_CAP.
  - Reset asserted mid-hold or mid-count aborts immediately. No state survives reset.
- **Tick prescaler**
  - Counts 0..TICK_DIV-1 and wraps.
  - tick is high for one clk cycle when the count equals TICK_DIV-1.
  - The first tick occurs TICK_DIV cycles after reset release.
- **Per-slot counters (x4)**
  - Each slot has occ, min[5:0] and sec[5:0].
  - On a tick, every occupied slot advances: sec 59 -> 0 with min+1.
  - The count saturates at 59:59 and stays there; it never wraps to 0:00.
  - Free slots hold 0:00.
- **Entry** (entry_signal at cycle T)
  - If the slot is free: occ=1 and counter=0:00 at T+1. A tick in cycle T does not count for that slot.
  - If the slot is already occupied: the entry is ignored and nothing changes.
- **Exit** (exit_signal at cycle T)
  - If the slot is occupied:
    - minutes/seconds load the slot's value at T (pre-tick, excluding any same-cycle tick).
    - exit_valid=1 for cycle T+1.
    - The slot's occ=0 and counter=0:00 at T+1.
    - FSM -> SHOW_TIME with hold counter = HOLD_SEC.
  - If the slot is free: the exit is ignored, with no pulse and no state change.
- **Simultaneous entry and exit**
  - Different slots: both are processed in the same cycle.
  - Same slot, occupied: the exit is processed and the entry is ignored.
  - Same slot, free: the entry is processed and the exit is ignored.
- **Display FSM**
  - SHOW_CAP: mode=0, minutes=seconds=0. A valid exit goes to SHOW_TIME.
  - SHOW_TIME: mode=1.
    - Each tick decrements the hold counter.
    - When a tick arrives with hold=1: go to SHOW_CAP next cycle and clear minutes/seconds to 0.
    - A new valid exit while in SHOW_TIME overwrites minutes/seconds, reloads hold=HOLD_SEC and pulses exit_valid.
  - A valid exit in the same cycle as the final hold tick wins: stay in SHOW_TIME with the new values.
- **Outputs and latency**
  - All outputs are registered.
  - Latency from exit pulse to display update is 1 cycle.
  - Width rules: the counter compare is against 59, hold uses 6 bits, and there is no arithmetic overflow.

Test Plan:
- **Reset state:** hold reset low, then release -> mode=0, minutes=0, seconds=0, occupied=4'b0000, exit_valid=0. Assert reset mid-SHOW_TIME -> all of these return to 0 in the same cycle (asynchronous).
- **Basic duration** (TICK_DIV=4, HOLD_SEC=5): entry slot 2; wait 75 ticks; exit slot 2 -> next cycle exit_valid=1, mode=1, minutes=1, seconds=15, occupied[2]=0. After 5 ticks -> mode=0, minutes=seconds=0.
- **Saturation and illegal events:**
  - Entry slot 0, wait 3700 ticks, exit slot 0 -> minutes=59, seconds=59.
  - Exit on free slot 3 -> no exit_valid; mode unchanged.
  - Entry on occupied slot 1 -> slot 1 count not reset.
- **Simultaneous events:**
  - Entry slot 1 and exit slot 0 (occupied, 10 s) in the same cycle -> occupied=4'b0010; display shows 00:10.
  - Entry and exit on occupied slot 3 -> slot 3 freed, entry ignored.
- **Re-trigger during hold:** exit slot 0 (20 s); 2 ticks later exit slot 1 (45 s) -> display switches to 00:45, hold restarts; mode returns to 0 exactly 5 ticks after the second exit.
- **Tick coincidence:** exit slot 2 in the exact tick cycle with slot at 00:09 -> captured 00:09 (pre-tick). Entry in a tick cycle -> slot reads 00:00 next cycle, 00:01 after the following tick.
